// File: rtl/rv32i_commit_tracer.sv
// rv32i_commit_tracer: store-trace FIFO, event counters and PC self-loop halt detector
// sitting beside the rv32i core.
module rv32i_commit_tracer #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 4,
   parameter int MODE        = 0,
   parameter int CNT_W       = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [XLEN-1:0]         pc,
   input  logic [XLEN-1:0]         aluResult,
   input  logic [XLEN-1:0]         writeData,
   input  logic                    memWrite,
   input  logic                    pcSrc,
   input  logic                    rd_ready,
   output logic                    rd_valid,
   output logic [XLEN-1:0]         rd_pc,
   output logic [XLEN-1:0]         rd_addr,
   output logic [XLEN-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    halted,
   output logic [CNT_W-1:0]        cycle_cnt,
   output logic [CNT_W-1:0]        store_cnt,
   output logic [CNT_W-1:0]        taken_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(HALT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t          state;
   logic [XLEN-1:0] mem_pc   [DEPTH];
   logic [XLEN-1:0] mem_addr [DEPTH];
   logic [XLEN-1:0] mem_data [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [XLEN-1:0] prev_pc;
   logic [SW-1:0]   same_cnt, same_nxt;
   logic            run, push, pop, full, keep, drop, rd_adv;
   assign run      = state == RUN;
   assign push     = run && memWrite;
   assign full     = count == (AW+1)'(DEPTH);
   assign rd_valid = count != '0;
   assign pop      = rd_valid && rd_ready;
   // a same-edge pop frees the slot, so a full FIFO only loses data without one
   assign drop     = push && full && !pop;
   assign keep     = push && (!drop || MODE == 1);
   assign rd_adv   = pop || (drop && MODE == 1);
   assign same_nxt = pc != prev_pc ? '0 : same_cnt == SW'(HALT_CYCLES) ? same_cnt : same_cnt + SW'(1);
   assign rd_pc    = rd_valid ? mem_pc[rd_ptr]   : '0;
   assign rd_addr  = rd_valid ? mem_addr[rd_ptr] : '0;
   assign rd_data  = rd_valid ? mem_data[rd_ptr] : '0;
   always_ff @(posedge clk) begin
      if (keep) begin
         mem_pc[wr_ptr]   <= pc;
         mem_addr[wr_ptr] <= aluResult;
         mem_data[wr_ptr] <= writeData;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         halted    <= 1'b0;
         cycle_cnt <= '0;
         store_cnt <= '0;
         taken_cnt <= '0;
         same_cnt  <= '0;
         prev_pc   <= '0;
      end else begin
         prev_pc  <= pc;
         overflow <= overflow | drop;
         if (keep) wr_ptr <= wr_ptr + AW'(1);
         if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
         if (keep && !rd_adv) count <= count + 1'b1;
         else if (!keep && rd_adv) count <= count - 1'b1;
         if (state == IDLE && enable) state <= RUN;
         if (run) begin
            same_cnt  <= same_nxt;
            cycle_cnt <= cycle_cnt + CNT_W'(cycle_cnt != '1);
            store_cnt <= store_cnt + CNT_W'(memWrite && store_cnt != '1);
            taken_cnt <= taken_cnt + CNT_W'(pcSrc && taken_cnt != '1);
            if (same_nxt == SW'(HALT_CYCLES)) begin
               state  <= HALT;
               halted <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_rv32i_commit_tracer.sv
// tb_rv32i_commit_tracer: drop (MODE 0) and overwrite (MODE 1) tracers on shared stimulus,
// directed test-plan scenarios then random traffic, against a queue-based model.
module tb_rv32i_commit_tracer;
   localparam int D = 4, HC = 4, CW = 6, CMAX = 63;
   typedef struct {logic [31:0] pc, addr, data;} ent_t;
   logic clk = 1'b0, reset, enable, memWrite, pcSrc, rd_ready;
   logic [31:0] pc, aluResult, writeData;
   logic rd_valid [2], overflow [2], halted [2];
   logic [31:0] rd_pc [2], rd_addr [2], rd_data [2];
   logic [2:0] count [2];
   logic [CW-1:0] cyc [2], st [2], tk [2];
   int checks = 0, errors = 0;
   int m_state = 0, m_same = 0, m_cyc = 0, m_st = 0, m_tk = 0;
   logic [31:0] m_prev = '0;
   bit m_ovf [2];
   ent_t q [2][$];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      rv32i_commit_tracer #(.XLEN(32), .DEPTH(D), .HALT_CYCLES(HC), .MODE(g), .CNT_W(CW)) dut (
         .clk(clk), .reset(reset), .enable(enable), .pc(pc), .aluResult(aluResult),
         .writeData(writeData), .memWrite(memWrite), .pcSrc(pcSrc), .rd_ready(rd_ready),
         .rd_valid(rd_valid[g]), .rd_pc(rd_pc[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
         .count(count[g]), .overflow(overflow[g]), .halted(halted[g]),
         .cycle_cnt(cyc[g]), .store_cnt(st[g]), .taken_cnt(tk[g]));
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic int sat(input int v);
      return v < CMAX ? v + 1 : CMAX;
   endfunction
   task automatic model();
      if (reset) begin
         m_state = 0; m_same = 0; m_prev = '0; m_cyc = 0; m_st = 0; m_tk = 0;
         for (int k = 0; k < 2; k++) begin q[k].delete(); m_ovf[k] = 0; end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (q[k].size() != 0 && rd_ready) void'(q[k].pop_front());
            if (m_state == 1 && memWrite) begin
               if (q[k].size() == D) begin
                  m_ovf[k] = 1;
                  if (k == 1) begin
                     void'(q[k].pop_front());
                     q[k].push_back('{pc, aluResult, writeData});
                  end
               end else q[k].push_back('{pc, aluResult, writeData});
            end
         end
         if (m_state == 0 && enable) m_state = 1;
         else if (m_state == 1) begin
            m_cyc = sat(m_cyc);
            if (memWrite) m_st = sat(m_st);
            if (pcSrc) m_tk = sat(m_tk);
            m_same = pc == m_prev ? (m_same < HC ? m_same + 1 : HC) : 0;
            if (m_same == HC) m_state = 2;
         end
         m_prev = pc;
      end
   endtask
   task automatic compare();
      for (int k = 0; k < 2; k++) begin
         ent_t h = '{32'h0, 32'h0, 32'h0};
         if (q[k].size() != 0) h = q[k][0];
         chk($sformatf("m%0d_rd_valid", k), 32'(rd_valid[k]), 32'(q[k].size() != 0));
         chk($sformatf("m%0d_rd_pc", k), rd_pc[k], h.pc);
         chk($sformatf("m%0d_rd_addr", k), rd_addr[k], h.addr);
         chk($sformatf("m%0d_rd_data", k), rd_data[k], h.data);
         chk($sformatf("m%0d_count", k), 32'(count[k]), q[k].size());
         chk($sformatf("m%0d_overflow", k), 32'(overflow[k]), 32'(m_ovf[k]));
         chk($sformatf("m%0d_halted", k), 32'(halted[k]), 32'(m_state == 2));
         chk($sformatf("m%0d_cycle_cnt", k), 32'(cyc[k]), m_cyc);
         chk($sformatf("m%0d_store_cnt", k), 32'(st[k]), m_st);
         chk($sformatf("m%0d_taken_cnt", k), 32'(tk[k]), m_tk);
      end
   endtask
   task automatic step(input bit rs, input bit en, input bit mw, input bit src, input bit rdy,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
      reset = rs; enable = en; memWrite = mw; pcSrc = src; rd_ready = rdy;
      pc = p; aluResult = a; writeData = d;
      @(posedge clk);
      model();
      #1 compare();
   endtask
   task automatic restart();
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 32'h1000, 0, 0);
   endtask
   initial begin
      logic [31:0] rp;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("reset_count", 32'(count[0]), 0);
      step(0, 1, 0, 0, 0, 32'h0c, 0, 0);
      step(0, 0, 1, 0, 0, 32'h10, 32'h100, 32'hAA);
      step(0, 0, 1, 0, 0, 32'h14, 32'h104, 32'hBB);
      chk("basic_count", 32'(count[0]), 2);
      chk("basic_head_pc", rd_pc[0], 32'h10);
      chk("basic_head_addr", rd_addr[0], 32'h100);
      chk("basic_head_data", rd_data[0], 32'hAA);
      step(0, 0, 0, 0, 1, 32'h18, 0, 0);
      chk("basic_pop_pc", rd_pc[0], 32'h14);
      chk("basic_pop_data", rd_data[0], 32'hBB);
      restart();
      for (int i = 1; i <= 6; i++) step(0, 0, 1, 0, 0, 32'h20 + 4 * i, 32'h200 + 4 * i, i);
      chk("ovf_count", 32'(count[0]), 4);
      chk("ovf_flag0", 32'(overflow[0]), 1);
      chk("ovf_flag1", 32'(overflow[1]), 1);
      chk("ovf_store_cnt", 32'(st[0]), 6);
      for (int i = 0; i < 4; i++) begin
         chk("drop_order", rd_data[0], i + 1);
         chk("overwrite_order", rd_data[1], i + 3);
         step(0, 0, 0, 0, 1, 32'h40 + 4 * i, 0, 0);
      end
      chk("drained", 32'(rd_valid[0]), 0);
      restart();
      for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, 1, 32'h60 + 4 * i, 32'h300 + i, 32'h50 + i);
      chk("pushpop_no_ovf", 32'(overflow[0]), 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 32'h0, 0, 0);
      step(0, 0, 1, 0, 0, 32'h0, 32'h400, 32'h77);
      step(0, 0, 0, 0, 0, 32'h4, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("halt_pre", 32'(halted[0]), 0);
         step(0, 0, 0, 1, 0, 32'h8, 0, 0);
      end
      chk("halt_set", 32'(halted[0]), 1);
      chk("halt_taken", 32'(tk[0]), 5);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 32'h8, 32'h500, 32'h99);
      chk("halt_taken_frozen", 32'(tk[0]), 5);
      chk("halt_drained", 32'(rd_valid[0]), 0);
      restart();
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 32'h80 + 4 * i, 32'h600, i);
      step(0, 0, 0, 0, 1, 32'h94, 0, 0);
      chk("pre_reset_count", 32'(count[0]), 3);
      step(1, 0, 1, 1, 1, 32'h98, 32'h700, 32'h1);
      chk("reset_mid_count", 32'(count[0]), 0);
      chk("reset_mid_ovf", 32'(overflow[0]), 0);
      step(0, 0, 1, 0, 0, 32'h9c, 32'h704, 32'h2);
      chk("no_capture_idle", 32'(count[0]), 0);
      step(0, 1, 0, 0, 0, 32'ha0, 0, 0);
      step(0, 0, 1, 0, 0, 32'ha4, 32'h708, 32'h3);
      chk("capture_after_enable", 32'(count[0]), 1);
      restart();
      rp = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0) rp = 32'h1000 + 4 * $urandom_range(0, 7);
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, rp, $urandom, $urandom);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv32i_commit_tracer.md
# rv32i_commit_tracer

Synthesisable, parametrised execution monitor for the `rv32i` core. It sits beside the core and taps the core's `pc`, `aluResult`, `writeData`, `memWrite` and `pcSrc` signals. It captures every store into a configurable-depth trace FIFO, counts cycles, stores and taken control transfers, and detects end-of-program as a PC self-loop. Benches and on-board debug logic drain the FIFO over a valid/ready port instead of scraping internal core signals.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `DEPTH`, 16: trace FIFO entries; must be a power of 2 and at least 2.
- `HALT_CYCLES`, 4: number of consecutive cycles with an unchanged PC that declares a halt; must be at least 1.
- `MODE`, 0: full-FIFO policy. 0 = drop the new entry. 1 = overwrite the oldest entry.
- `CNT_W`, 32: width of each event counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  arms capture; sampled only in IDLE.
- `pc`  in  XLEN  PC of the current instruction.
- `aluResult`  in  XLEN  store address when `memWrite`=1.
- `writeData`  in  XLEN  store data when `memWrite`=1.
- `memWrite`  in  1  the current instruction is a store.
- `pcSrc`  in  1  taken branch or jump in the current cycle.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  FIFO is non-empty.
- `rd_pc`, `rd_addr`, `rd_data`  out  XLEN each  head entry fields.
- `count`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; at least one entry was dropped or overwritten.
- `halted`  out  1  state machine is in HALT.
- `cycle_cnt`, `store_cnt`, `taken_cnt`  out  CNT_W each  event counters.

## Operation
State machine, one-hot or encoded: IDLE, RUN, HALT.
- IDLE → RUN on an edge with `enable`=1. Nothing is captured or counted in IDLE, including on that edge.
- RUN → HALT on the edge where `pc == prev_pc` has held for `HALT_CYCLES` consecutive sampled cycles.
  - `prev_pc` is `pc` registered on every edge.
  - `same_cnt` increments on a match and clears on a mismatch. It saturates at `HALT_CYCLES`.
  - `prev_pc` loads on the IDLE→RUN edge. Matching starts on the first RUN cycle.
- HALT is left only by `reset`. In HALT, capture and counters are frozen, and FIFO draining continues.

Capture and counting, applied on edges in RUN, including the RUN→HALT edge:
- `memWrite`=1 pushes {`pc`, `aluResult`, `writeData`}.
- `cycle_cnt` increments every edge.
- `store_cnt` increments on every `memWrite`, whether or not the entry was kept.
- `taken_cnt` increments on `pcSrc`.
- All counters saturate at 2^CNT_W−1.

FIFO behaviour:
- The FIFO is first-word fall-through. `rd_*` show the head entry whenever `rd_valid`=1, and are 0 when the FIFO is empty.
- A pop occurs when `rd_valid && rd_ready`.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Push while full, without a pop:
  - MODE 0: the new entry is discarded.
  - MODE 1: the oldest entry is dropped, read and write pointers both advance, and `count` stays DEPTH.
  - In both modes, `overflow` sets.
- Push and pop on the same edge while full: both take effect, `count` is unchanged, and `overflow` is not set.
- Push and pop on the same edge while empty: the push is taken, no pop occurs (`rd_valid` was 0), and `count` becomes 1.
- Pop while empty: ignored.

## Timing
- Reset values (edge with `reset`=1, any state, including mid-capture or mid-drain):
  - state = IDLE.
  - FIFO flushed: `count`=0, `rd_valid`=0, `rd_*`=0.
  - `overflow`=0, `halted`=0, all counters 0, `same_cnt`=0, `prev_pc`=0.
- `reset` has priority over every other input on the same edge.
- Push latency: an entry pushed at edge k gives `rd_valid`=1 with that entry visible after edge k, if the FIFO was empty.
- All outputs come directly from registers, except `rd_*` and `rd_valid`, which decode from the registered pointers and storage array. There is no combinational path from inputs to outputs.
- `halted` rises in the cycle after the detecting edge. The counters show their final values in the same cycle.

## Test plan
- Basic trace (`DEPTH`=4, `MODE`=0): `enable`=1, then stores at pc 0x10 (addr 0x100, data 0xAA) and pc 0x14 (addr 0x104, data 0xBB), `rd_ready`=0 → `count`=2, head = {0x10, 0x100, 0xAA}. Then raise `rd_ready` for one cycle → head becomes {0x14, 0x104, 0xBB}.
- Overflow, `MODE`=0: 6 stores with data 1..6 and no reads → `count`=4, `overflow`=1, `store_cnt`=6, drained order 1,2,3,4.
- Overflow, `MODE`=1: same stimulus → drained order 3,4,5,6, `overflow`=1.
- Full with simultaneous push and pop, `MODE`=0: `rd_ready`=1 held during stores → no entry lost, `overflow`=0.
- Halt (`HALT_CYCLES`=4): pc sequence 0x0, 0x4, 0x8, 0x8, 0x8, 0x8, 0x8 with `pcSrc`=1 on the 0x8 cycles → `halted`=1 after the 4th repeat; `taken_cnt` and `cycle_cnt` freeze, and the FIFO is still drainable.
- Reset mid-operation: assert `reset` with `count`=3 and `overflow`=1 → next cycle all outputs are 0. A later store is not captured until `enable` is set again.
